// File: rtl/demux_stream_1_4_if.sv
// demux_stream_1_4_if: upstream stream, four-channel downstream bus
// and debug counters of the 1-to-4 stream demultiplexer.
interface demux_stream_1_4_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_sel;
    logic              rr_mode;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;
    logic [4*CNT_W-1:0] cnt;

    modport master (
        output in_valid, in_data, in_sel, rr_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sel, cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, rr_mode, out_ready,
        output in_ready, out_valid, out_data, out_sel, cnt
    );
endinterface

// File: rtl/demux_stream_1_4.sv
// demux_stream_1_4: one-word registered 1-to-4 stream demultiplexer
// with addressed or round-robin dispatch and per-channel counters.
module demux_stream_1_4 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic               clk,
    input logic               rst,
    demux_stream_1_4_if.slave s
);
    logic              hold_valid;
    logic [1:0]        hold_sel;
    logic [DATA_W-1:0] hold_data;
    logic [1:0]        rr_ptr;
    logic [CNT_W-1:0]  cnt_q [4];

    logic       accept;
    logic       deliver;
    logic [1:0] eff_sel;

    // Only the held word's channel can stall the stage.
    assign deliver = hold_valid && s.out_ready[hold_sel];
    assign s.in_ready = !rst && (!hold_valid || s.out_ready[hold_sel]);
    assign accept  = s.in_valid && s.in_ready;
    assign eff_sel = s.rr_mode ? rr_ptr : s.in_sel;

    assign s.out_valid = hold_valid ? (4'b0001 << hold_sel) : 4'b0000;
    assign s.out_data  = hold_data;
    assign s.out_sel   = hold_sel;

    always_comb begin
        s.cnt = '0;
        for (int i = 0; i < 4; i++) begin
            s.cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_sel   <= '0;
            hold_data  <= '0;
            rr_ptr     <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_sel   <= eff_sel;
                hold_data  <= s.in_data;
            end else if (deliver) begin
                hold_valid <= 1'b0;
            end
            if (accept && s.rr_mode) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (deliver && hold_sel == 2'(i)) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_demux_stream_1_4.sv
// tb_demux_stream_1_4: directed bench with a transaction-level model,
// a per-cycle compare process and literal spot checks.
module tb_demux_stream_1_4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       iv   = 1'b0;
    logic       rrm  = 1'b0;
    logic [7:0] id   = 8'h00;
    logic [1:0] isel = 2'd0;
    logic [3:0] ordy = 4'b0000;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    demux_stream_1_4_if #(.DATA_W(8), .CNT_W(8)) bus ();
    demux_stream_1_4_if #(.DATA_W(8), .CNT_W(2)) bus2 ();

    assign bus.in_valid   = iv;
    assign bus.in_data    = id;
    assign bus.in_sel     = isel;
    assign bus.rr_mode    = rrm;
    assign bus.out_ready  = ordy;
    assign bus2.in_valid  = iv;
    assign bus2.in_data   = id;
    assign bus2.in_sel    = isel;
    assign bus2.rr_mode   = rrm;
    assign bus2.out_ready = ordy;

    demux_stream_1_4 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    demux_stream_1_4 #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .s   (bus2.slave)
    );

    // Model: the held word, total rr dispatches, total deliveries per channel.
    bit         started = 1'b0;
    bit         m_valid = 1'b0;
    logic [1:0] m_sel   = 2'd0;
    logic [7:0] m_data  = 8'h00;
    int         rr_n    = 0;
    int         dcount [4];

    always @(posedge clk) begin
        bit acc;
        bit del;
        cyc++;
        if (rst) begin
            started = 1'b1;
            m_valid = 1'b0;
            m_sel   = 2'd0;
            m_data  = 8'h00;
            rr_n    = 0;
            for (int i = 0; i < 4; i++) dcount[i] = 0;
        end else begin
            del = m_valid && ordy[m_sel];
            acc = iv && (!m_valid || del);
            if (del) dcount[m_sel] = dcount[m_sel] + 1;
            if (acc) begin
                m_sel   = rrm ? 2'(rr_n % 4) : isel;
                m_data  = id;
                m_valid = 1'b1;
                if (rrm) rr_n = rr_n + 1;
            end else if (del) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0]  ev;
        logic [31:0] e8;
        logic [7:0]  e2;
        if (started) begin
            ev = m_valid ? 4'(1 << m_sel) : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                e8[i*8 +: 8] = 8'(dcount[i] % 256);
                e2[i*2 +: 2] = 2'(dcount[i] % 4);
            end
            cmp("out_valid", 32'(bus.out_valid), 32'(ev));
            cmp("in_ready", 32'(bus.in_ready),
                32'(!rst && (!m_valid || ordy[m_sel])));
            cmp("out_data", 32'(bus.out_data), 32'(m_data));
            cmp("out_sel", 32'(bus.out_sel), 32'(m_sel));
            cmp("cnt", bus.cnt, e8);
            cmp("cnt_w2", 32'(bus2.cnt), 32'(e2));
            cmp("out_valid_w2", 32'(bus2.out_valid), 32'(ev));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iv  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset held two cycles, then idle.
        step();
        step();
        rst = 1'b0;
        #1;
        cmp("idle_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        cmp("idle_out_valid", 32'(bus.out_valid), 32'h0);
        cmp("idle_out_data", 32'(bus.out_data), 32'h0);
        cmp("idle_cnt", bus.cnt, 32'h0);

        // Addressed routing, back to back.
        rrm  = 1'b0;
        ordy = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            iv   = 1'b1;
            id   = 8'hA0 + 8'(k);
            isel = 2'(k);
            step();
            cmp("addr_valid", 32'(bus.out_valid), 32'(1 << k));
            cmp("addr_data", 32'(bus.out_data), 32'hA0 + 32'(k));
        end
        iv = 1'b0;
        step();
        cmp("addr_cnt", bus.cnt, 32'h01010101);
        cmp("addr_cnt_w2", 32'(bus2.cnt), 32'h55);

        // Backpressure on channel 2.
        do_reset();
        isel = 2'd2;
        ordy = 4'b1011;
        iv   = 1'b1;
        id   = 8'h55;
        step();
        id = 8'h66;
        for (int k = 0; k < 5; k++) begin
            step();
            cmp("bp_valid", 32'(bus.out_valid), 32'h4);
            cmp("bp_data", 32'(bus.out_data), 32'h55);
            cmp("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        ordy = 4'b1111;
        step();
        iv = 1'b0;
        cmp("bp_swap_data", 32'(bus.out_data), 32'h66);
        cmp("bp_swap_valid", 32'(bus.out_valid), 32'h4);
        cmp("bp_cnt2", 32'(bus.cnt[23:16]), 32'd1);
        step();

        // Round robin ignores in_sel.
        do_reset();
        rrm  = 1'b1;
        isel = 2'd3;
        for (int k = 0; k < 6; k++) begin
            iv = 1'b1;
            id = 8'hB0 + 8'(k);
            step();
            cmp("rr_chan", 32'(bus.out_sel), 32'(k % 4));
        end
        iv = 1'b0;
        step();
        cmp("rr_cnt", bus.cnt, 32'h01010202);
        cmp("model_rr_cnt0", 32'(dcount[0]), 32'd2);
        // Addressed word, then rr resumes at pointer 2.
        rrm = 1'b0;
        iv  = 1'b1;
        id  = 8'hB6;
        step();
        cmp("toggle_addr", 32'(bus.out_sel), 32'd3);
        rrm = 1'b1;
        id  = 8'hB7;
        step();
        iv = 1'b0;
        cmp("toggle_rr", 32'(bus.out_sel), 32'd2);
        step();

        // Counter wrap on the 2-bit instance.
        do_reset();
        rrm  = 1'b0;
        isel = 2'd1;
        for (int k = 0; k < 5; k++) begin
            iv = 1'b1;
            id = 8'hC0 + 8'(k);
            step();
            if (k > 0) cmp("wrap_cnt1", 32'(bus2.cnt[3:2]), 32'(k % 4));
        end
        iv = 1'b0;
        step();
        cmp("wrap_cnt1_last", 32'(bus2.cnt[3:2]), 32'd1);
        cmp("wrap_cnt1_w8", 32'(bus.cnt[15:8]), 32'd5);

        // Reset while a word stalls on channel 3.
        do_reset();
        rrm = 1'b1;
        iv  = 1'b1;
        id  = 8'hD0;
        step();
        rrm  = 1'b0;
        isel = 2'd3;
        id   = 8'hD3;
        step();
        ordy = 4'b0000;
        iv   = 1'b0;
        step();
        cmp("stall_valid", 32'(bus.out_valid), 32'h8);
        rst = 1'b1;
        iv  = 1'b1;
        id  = 8'hFF;
        #1;
        cmp("rst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        cmp("rst_valid", 32'(bus.out_valid), 32'h0);
        cmp("rst_data", 32'(bus.out_data), 32'h0);
        cmp("rst_cnt", bus.cnt, 32'h0);
        rst  = 1'b0;
        rrm  = 1'b1;
        ordy = 4'b1111;
        id   = 8'hE1;
        step();
        iv = 1'b0;
        cmp("post_rst_valid", 32'(bus.out_valid), 32'h1);
        cmp("post_rst_data", 32'(bus.out_data), 32'hE1);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demux_stream_1_4.md
Name: demux_stream_1_4

Overview:
- Sequential front end for the 1-to-4 demultiplexer path: accepts a valid/ready data stream and routes each word to exactly one of four output channels.
- Channel selection is either addressed by a per-word select or round-robin.
- Holds one word in a registered stage so that each channel can apply backpressure independently.
- Keeps a wrap-around delivered-word counter per channel for bring-up and debug.

Parameters:
- DATA_W, 8, width of the data word.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can take a word this cycle.
- in_data  input  DATA_W  upstream word.
- in_sel  input  2  destination channel (0..3); used only when rr_mode=0.
- rr_mode  input  1  1 = round-robin dispatch, 0 = addressed by in_sel.
- out_valid  output  4  one-hot channel valid; all zeros when the block is empty.
- out_ready  input  4  per-channel ready.
- out_data  output  DATA_W  shared data bus for all channels.
- out_sel  output  2  channel index of the held word.
- cnt  output  4*CNT_W  delivered-word counters; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Internal state:
  - hold_valid, hold_sel[1:0], hold_data[DATA_W-1:0].
  - rr_ptr[1:0].
  - cnt0..cnt3.
- Combinational outputs:
  - out_valid = hold_valid ? (4'b0001 << hold_sel) : 4'b0000.
  - out_data = hold_data; out_sel = hold_sel.
  - in_ready = !rst && (!hold_valid || out_ready[hold_sel]).
  - out_ready bits of non-selected channels are ignored.
- Events:
  - accept = in_valid && in_ready.
  - deliver = hold_valid && out_ready[hold_sel].
- Effective select: eff_sel = rr_mode ? rr_ptr : in_sel.
- Registered update (rst=0):
  - accept (with or without deliver): hold_valid<=1, hold_sel<=eff_sel, hold_data<=in_data.
  - deliver without accept: hold_valid<=0; hold_sel and hold_data keep their values.
  - neither: hold unchanged.
  - accept && rr_mode: rr_ptr <= rr_ptr+1, wrapping from 3 to 0. rr_ptr is unchanged otherwise.
  - deliver: cnt[hold_sel] <= cnt[hold_sel]+1, wrapping from 2^CNT_W-1 to 0. The counter updates in the same edge as the transfer.
- Latency and throughput:
  - Word accepted at edge N appears on out_valid/out_data after edge N.
  - Sustained 1 word/cycle while the selected channel's ready stays high.
  - A simultaneous deliver+accept replaces the held word with no bubble.
- Backpressure: while the held word's channel is not ready, in_ready=0 and the held word stays stable. Data and select must not change while out_valid is nonzero and undelivered.
- Mode switching:
  - Changing rr_mode or in_sel never alters an already-held word.
  - rr_ptr keeps its value across mode toggles; only reset clears it.
- Reset (synchronous, any time):
  - hold_valid=0, hold_sel=0, hold_data=0, rr_ptr=0, all cnt=0.
  - out_valid=0000, out_data=0, out_sel=0, in_ready=0 during the reset cycle.
  - A word held at reset is discarded and not counted.
  - A word presented in the reset cycle is not accepted.
- No X propagation: out_valid must be a defined 4-bit value in every cycle after the first reset edge.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then in_valid=0 → out_valid=0000, out_data=0, in_ready=1 after release, all cnt=0.
- Addressed routing:
  - rr_mode=0, out_ready=1111, send 0xA0..0xA3 with in_sel=0,1,2,3 on consecutive cycles → out_valid=0001,0010,0100,1000 on the following cycles, matching data, no bubbles.
  - Afterwards each cnt=1.
- Backpressure:
  - rr_mode=0, in_sel=2, out_ready=1011, send 0x55 then 0x66 → out_valid=0100 with 0x55 held and in_ready=0 for 5 cycles.
  - Raise out_ready[2] → 0x55 delivered, 0x66 accepted in the same edge, cnt2=1.
- Round-robin:
  - rr_mode=1, out_ready=1111, 6 back-to-back words with in_sel=3 → channels 0,1,2,3,0,1.
  - cnt0=2, cnt1=2, cnt2=1, cnt3=1, rr_ptr=2.
- Counter wrap with CNT_W=2:
  - 5 deliveries to channel 1 → cnt1 reads 1,2,3,0,1.
- Reset mid-operation:
  - Hold word on stalled channel 3 (out_ready=0000), assert rst one cycle → out_valid=0000, held word lost, cnt3 unchanged at 0, rr_ptr=0.
  - Next accepted word routes normally.
